// File: rtl/wb_regfile_pkg.sv
// Shared sizes, bundle types and helpers for the write-back stage
// and the architectural register file.
package wb_regfile_pkg;

   localparam int DSIZE    = 32;
   localparam int ASIZE    = 5;
   localparam int ISIZE    = 32;
   localparam int DEPTH    = 1 << ASIZE;
   localparam int LINK_REG = 31;
   localparam int LINK_INC = 4;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_LINK
   } wb_sel_e;

   typedef struct packed {
      logic             wen;
      logic [ASIZE-1:0] addr;
      logic [DSIZE-1:0] data;
   } wb_bus_t;

   // Link value wraps modulo 2**ISIZE; any carry out is dropped.
   function automatic logic [DSIZE-1:0] link_val(
      input logic [ISIZE-1:0] pc
   );
      logic [ISIZE-1:0] sum;
      sum = pc + ISIZE'(LINK_INC);
      return DSIZE'(sum);
   endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB inputs, ID read ports, forwarding bus and debug counter
// of the write-back stage, bundled for a single port connection.
interface wb_regfile_if;
   import wb_regfile_pkg::*;

   logic             wen_in;
   logic [DSIZE-1:0] w_data_in;
   logic [ASIZE-1:0] w_addr_in;
   logic [ISIZE-1:0] PC_in;
   logic             jal_in;
   logic             MemtoReg_in;
   logic [DSIZE-1:0] readMem_in;
   logic [ASIZE-1:0] raddr1;
   logic [ASIZE-1:0] raddr2;
   logic [DSIZE-1:0] rdata1;
   logic [DSIZE-1:0] rdata2;
   logic             wb_wen;
   logic [ASIZE-1:0] wb_addr;
   logic [DSIZE-1:0] wb_data;
   logic [31:0]      commit_cnt;

   modport master (
      output wen_in, w_data_in, w_addr_in,
      output PC_in, jal_in, MemtoReg_in,
      output readMem_in, raddr1, raddr2,
      input  rdata1, rdata2,
      input  wb_wen, wb_addr, wb_data,
      input  commit_cnt
   );

   modport slave (
      input  wen_in, w_data_in, w_addr_in,
      input  PC_in, jal_in, MemtoReg_in,
      input  readMem_in, raddr1, raddr2,
      output rdata1, rdata2,
      output wb_wen, wb_addr, wb_data,
      output commit_cnt
   );

endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// 32-entry register file: one write port, two read ports,
// r0 hardwired to zero and same-cycle write-through bypass.
module regfile_2r1w
   import wb_regfile_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr1,
   input  logic [ASIZE-1:0] raddr2,
   output logic [DSIZE-1:0] rdata1,
   output logic [DSIZE-1:0] rdata2
);

   logic [DSIZE-1:0] regs [DEPTH];
   logic             hit1;
   logic             hit2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   // r0 excluded from the hit so the case arms stay disjoint.
   assign hit1 = we && raddr1 == waddr
              && raddr1 != '0;
   assign hit2 = we && raddr2 == waddr
              && raddr2 != '0;

   always_comb begin
      rdata1 = '0;
      unique case (1'b1)
         (raddr1 == '0): rdata1 = '0;
         hit1:           rdata1 = wdata;
         default:        rdata1 = regs[raddr1];
      endcase
   end

   always_comb begin
      rdata2 = '0;
      unique case (1'b1)
         (raddr2 == '0): rdata2 = '0;
         hit2:           rdata2 = wdata;
         default:        rdata2 = regs[raddr2];
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, effective write enable,
// commit counter, and the architectural register file.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus
);

   wb_sel_e     sel;
   wb_bus_t     wb;
   logic [31:0] commit_q;

   // JAL wins over a stray MemtoReg on the same instruction.
   always_comb begin
      sel = WB_ALU;
      if (bus.jal_in)
         sel = WB_LINK;
      else if (bus.MemtoReg_in)
         sel = WB_MEM;
   end

   always_comb begin
      wb.data = bus.w_data_in;
      wb.addr = bus.w_addr_in;
      unique case (sel)
         WB_LINK: begin
            wb.data = link_val(bus.PC_in);
            wb.addr = ASIZE'(LINK_REG);
         end
         WB_MEM:  wb.data = bus.readMem_in;
         default: wb.data = bus.w_data_in;
      endcase
      wb.wen = (bus.wen_in | bus.jal_in)
            && wb.addr != '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         commit_q <= '0;
      else if (wb.wen)
         commit_q <= commit_q + 32'd1;
   end

   regfile_2r1w u_rf (
      .clk    (clk),
      .rst    (rst),
      .we     (wb.wen),
      .waddr  (wb.addr),
      .wdata  (wb.data),
      .raddr1 (bus.raddr1),
      .raddr2 (bus.raddr2),
      .rdata1 (bus.rdata1),
      .rdata2 (bus.rdata2)
   );

   assign bus.wb_wen     = wb.wen;
   assign bus.wb_addr    = wb.addr;
   assign bus.wb_data    = wb.data;
   assign bus.commit_cnt = commit_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: write-back select, bypass,
// r0 suppression, reset behaviour and counter wrap.
module tb_wb_regfile;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs change 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wen_in      = 1'b0;
      bus.jal_in      = 1'b0;
      bus.MemtoReg_in = 1'b0;
   endtask

   task automatic wr(
      input logic [4:0]  a,
      input logic [31:0] d
   );
      idle();
      bus.wen_in    = 1'b1;
      bus.w_addr_in = a;
      bus.w_data_in = d;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b0;
      bus.wen_in      = 1'b1;
      bus.jal_in      = 1'b0;
      bus.MemtoReg_in = 1'b0;
      bus.w_addr_in   = 5'd5;
      bus.w_data_in   = $urandom;
      bus.PC_in       = $urandom;
      bus.readMem_in  = $urandom;
      bus.raddr1      = 5'd0;
      bus.raddr2      = 5'd0;

      // Clock edges with a live write while held in reset.
      step();
      step();
      bus.wen_in    = 1'b0;
      bus.w_addr_in = 5'($urandom);
      bus.w_data_in = $urandom;
      #1;
      for (int i = 0; i < 32; i++) begin
         bus.raddr1 = 5'(i);
         bus.raddr2 = 5'(31 - i);
         #1;
         chk("rst_rd1", bus.rdata1, 32'h0);
         chk("rst_rd2", bus.rdata2, 32'h0);
      end
      chk("rst_cnt", bus.commit_cnt, 32'h0);

      step();
      rst = 1'b1;
      step();

      // ALU write with same-cycle bypass.
      wr(5'd7, 32'hDEADBEEF);
      bus.raddr1 = 5'd7;
      #1;
      chk("byp_rd1", bus.rdata1, 32'hDEADBEEF);
      chk("byp_wen", 32'(bus.wb_wen), 32'd1);
      chk("byp_addr", 32'(bus.wb_addr), 32'd7);
      step();
      idle();
      #1;
      chk("r7_hold", bus.rdata1, 32'hDEADBEEF);
      chk("cnt_1", bus.commit_cnt, 32'd1);

      // Load data selected over ALU result.
      wr(5'd3, 32'h11111111);
      bus.MemtoReg_in = 1'b1;
      bus.readMem_in  = 32'hCAFEF00D;
      #1;
      chk("mem_wbd", bus.wb_data, 32'hCAFEF00D);
      step();
      idle();
      bus.raddr1 = 5'd3;
      #1;
      chk("r3_mem", bus.rdata1, 32'hCAFEF00D);

      wr(5'd9, 32'h99999999);
      step();
      idle();

      // JAL: link value to r31, w_addr_in ignored.
      bus.jal_in    = 1'b1;
      bus.PC_in     = 32'h00400010;
      bus.w_addr_in = 5'd9;
      bus.w_data_in = 32'h55555555;
      #1;
      chk("jal_addr", 32'(bus.wb_addr), 32'd31);
      chk("jal_data", bus.wb_data, 32'h00400014);
      chk("jal_wen", 32'(bus.wb_wen), 32'd1);
      step();
      idle();
      bus.raddr1 = 5'd31;
      bus.raddr2 = 5'd9;
      #1;
      chk("r31_link", bus.rdata1, 32'h00400014);
      chk("r9_keep", bus.rdata2, 32'h99999999);
      chk("cnt_4", bus.commit_cnt, 32'd4);

      // JAL link wraps; MemtoReg must not override it.
      bus.jal_in      = 1'b1;
      bus.MemtoReg_in = 1'b1;
      bus.readMem_in  = 32'h77777777;
      bus.PC_in       = 32'hFFFFFFFE;
      step();
      idle();
      #1;
      chk("r31_wrap", bus.rdata1, 32'h00000002);

      // Writes to r0 are never effective.
      wr(5'd0, 32'hFFFFFFFF);
      bus.raddr1 = 5'd0;
      #1;
      chk("r0_wen", 32'(bus.wb_wen), 32'd0);
      chk("r0_byp", bus.rdata1, 32'h0);
      step();
      idle();
      #1;
      chk("r0_rd", bus.rdata1, 32'h0);
      chk("r0_cnt", bus.commit_cnt, 32'd5);

      // Both ports on the address being written.
      wr(5'd4, 32'h44444444);
      bus.raddr1 = 5'd4;
      bus.raddr2 = 5'd4;
      #1;
      chk("dual_byp1", bus.rdata1, 32'h44444444);
      chk("dual_byp2", bus.rdata2, 32'h44444444);
      step();
      idle();
      bus.w_data_in = 32'h0;
      #1;
      chk("bubble_wen", 32'(bus.wb_wen), 32'd0);
      step();
      chk("dual_rd1", bus.rdata1, 32'h44444444);
      chk("dual_rd2", bus.rdata2, 32'h44444444);
      chk("cnt_6", bus.commit_cnt, 32'd6);

      // Asynchronous reset mid-run, then a write under reset.
      wr(5'd5, 32'h00001234);
      step();
      idle();
      bus.raddr1 = 5'd5;
      #1;
      chk("r5_set", bus.rdata1, 32'h00001234);
      rst = 1'b0;
      #1;
      chk("r5_arst", bus.rdata1, 32'h0);
      chk("cnt_arst", bus.commit_cnt, 32'h0);
      wr(5'd6, 32'h0000ABCD);
      step();
      idle();
      rst = 1'b1;
      bus.raddr2 = 5'd6;
      #1;
      chk("r6_drop", bus.rdata2, 32'h0);
      chk("cnt_drop", bus.commit_cnt, 32'h0);

      // Counter wrap from all-ones.
      force dut.commit_q = 32'hFFFFFFFF;
      #1;
      release dut.commit_q;
      #1;
      chk("cnt_max", bus.commit_cnt, 32'hFFFFFFFF);
      wr(5'd8, 32'h00000001);
      step();
      idle();
      bus.raddr1 = 5'd8;
      #1;
      chk("cnt_wrap", bus.commit_cnt, 32'h0);
      chk("r8_wr", bus.rdata1, 32'h00000001);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
